// File: rtl/alu_sequencer.sv
// alu_sequencer: T-state control sequencer for the Mini SRC datapath.
// Fetches, decodes and executes register-register ALU instructions.
module alu_sequencer #(
  parameter int REG_COUNT = 16,
  parameter int OPC_WIDTH = 5,
  parameter int MEM_WAIT  = 0
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 run,
  input  logic [31:0]          ir,
  output logic                 PC_out,
  output logic                 MAR_in,
  output logic                 IncPC,
  output logic                 Z_in,
  output logic                 Zlow_out,
  output logic                 Zhigh_out,
  output logic                 PC_in,
  output logic                 Read,
  output logic                 MDR_in,
  output logic                 MDR_out,
  output logic                 IR_in,
  output logic                 Y_in,
  output logic                 LO_in,
  output logic                 HI_in,
  output logic [REG_COUNT-1:0] R_in,
  output logic [REG_COUNT-1:0] R_out,
  output logic [OPC_WIDTH-1:0] alu_instruction,
  output logic                 busy,
  output logic                 done,
  output logic                 fault
);

  localparam int RW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int LSB = 32 - OPC_WIDTH - 3 * RW;
  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);
  localparam logic [REG_COUNT-1:0] REG_ONE = REG_COUNT'(1);

  localparam logic [OPC_WIDTH-1:0] OP_ADD  = OPC_WIDTH'(3);
  localparam logic [OPC_WIDTH-1:0] OP_SUB  = OPC_WIDTH'(4);
  localparam logic [OPC_WIDTH-1:0] OP_AND  = OPC_WIDTH'(5);
  localparam logic [OPC_WIDTH-1:0] OP_OR   = OPC_WIDTH'(6);
  localparam logic [OPC_WIDTH-1:0] OP_SHR  = OPC_WIDTH'(7);
  localparam logic [OPC_WIDTH-1:0] OP_SHRA = OPC_WIDTH'(8);
  localparam logic [OPC_WIDTH-1:0] OP_SHL  = OPC_WIDTH'(9);
  localparam logic [OPC_WIDTH-1:0] OP_ROR  = OPC_WIDTH'(10);
  localparam logic [OPC_WIDTH-1:0] OP_ROL  = OPC_WIDTH'(11);
  localparam logic [OPC_WIDTH-1:0] OP_MUL  = OPC_WIDTH'(15);
  localparam logic [OPC_WIDTH-1:0] OP_DIV  = OPC_WIDTH'(16);
  localparam logic [OPC_WIDTH-1:0] OP_NEG  = OPC_WIDTH'(17);
  localparam logic [OPC_WIDTH-1:0] OP_NOT  = OPC_WIDTH'(18);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_FAULT
  } state_t;

  state_t r_state;
  state_t w_next;
  logic [2:0] r_wait;
  logic r_fault;

  logic [OPC_WIDTH-1:0] w_opc;
  logic [RW-1:0] w_ra;
  logic [RW-1:0] w_rb;
  logic [RW-1:0] w_rc;
  logic [REG_COUNT-1:0] w_ra_oh;
  logic [REG_COUNT-1:0] w_rb_oh;
  logic [REG_COUNT-1:0] w_rc_oh;
  logic w_two;
  logic w_una;
  logic w_md;
  logic w_legal_two;
  logic w_legal_una;
  logic w_unused;

  assign w_opc = ir[31 -: OPC_WIDTH];
  assign w_ra  = ir[31-OPC_WIDTH -: RW];
  assign w_rb  = ir[31-OPC_WIDTH-RW -: RW];
  assign w_rc  = ir[31-OPC_WIDTH-2*RW -: RW];
  assign w_unused = ^ir[LSB-1:0];

  // Out-of-range indices shift out to zero, which doubles as the range check.
  assign w_ra_oh = REG_ONE << w_ra;
  assign w_rb_oh = REG_ONE << w_rb;
  assign w_rc_oh = REG_ONE << w_rc;

  assign w_md  = (w_opc == OP_MUL) || (w_opc == OP_DIV);
  assign w_una = (w_opc == OP_NEG) || (w_opc == OP_NOT);
  assign w_two = w_md
    || (w_opc == OP_ADD) || (w_opc == OP_SUB)
    || (w_opc == OP_AND) || (w_opc == OP_OR)
    || (w_opc == OP_SHR) || (w_opc == OP_SHRA)
    || (w_opc == OP_SHL) || (w_opc == OP_ROR)
    || (w_opc == OP_ROL);

  assign w_legal_two = w_two && (|w_ra_oh) && (|w_rb_oh) && (|w_rc_oh);
  assign w_legal_una = w_una && (|w_ra_oh) && (|w_rb_oh);

  // State register, memory wait counter and sticky fault flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_wait  <= 3'd0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T0) begin
        r_wait <= WAIT_INIT;
      end else if (r_state == S_T1 && r_wait != 3'd0) begin
        r_wait <= r_wait - 3'd1;
      end
      if (r_state == S_FAULT) begin
        r_fault <= 1'b1;
      end else if (r_state == S_IDLE && start) begin
        r_fault <= 1'b0;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    if (r_wait == 3'd0) w_next = S_T2;
      S_T2:    w_next = w_legal_una ? S_T4 : S_T3;
      S_T3:    w_next = w_legal_two ? S_T4 : S_FAULT;
      S_T4:    w_next = S_T5;
      S_T5: begin
        if (w_md) w_next = S_T6;
        else      w_next = run ? S_T0 : S_IDLE;
      end
      S_T6:    w_next = run ? S_T0 : S_IDLE;
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore strobe decode from state and IR fields.
  always_comb begin
    PC_out = 1'b0;
    MAR_in = 1'b0;
    IncPC = 1'b0;
    Z_in = 1'b0;
    Zlow_out = 1'b0;
    Zhigh_out = 1'b0;
    PC_in = 1'b0;
    Read = 1'b0;
    MDR_in = 1'b0;
    MDR_out = 1'b0;
    IR_in = 1'b0;
    Y_in = 1'b0;
    LO_in = 1'b0;
    HI_in = 1'b0;
    R_in = '0;
    R_out = '0;
    alu_instruction = '0;
    done = 1'b0;
    unique case (r_state)
      S_T0: begin
        PC_out = 1'b1;
        MAR_in = 1'b1;
        IncPC = 1'b1;
        Z_in = 1'b1;
      end
      S_T1: begin
        Read = 1'b1;
        MDR_in = 1'b1;
        if (r_wait == WAIT_INIT) begin
          Zlow_out = 1'b1;
          PC_in = 1'b1;
        end
      end
      S_T2: begin
        MDR_out = 1'b1;
        IR_in = 1'b1;
      end
      S_T3: begin
        if (w_legal_two) begin
          R_out = w_rb_oh;
          Y_in = 1'b1;
        end
      end
      S_T4: begin
        R_out = w_una ? w_rb_oh : w_rc_oh;
        alu_instruction = w_opc;
        Z_in = 1'b1;
      end
      S_T5: begin
        Zlow_out = 1'b1;
        if (w_md) begin
          LO_in = 1'b1;
        end else begin
          R_in = w_ra_oh;
          done = 1'b1;
        end
      end
      S_T6: begin
        Zhigh_out = 1'b1;
        HI_in = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  assign fault = r_fault;

endmodule
